// File: rtl/terminal_array.sv
// terminal_array: per-clause terminal evaluation with a serialized conflict
// report channel.
//
// A round is started by start_i in IDLE. One cycle later (CAPTURE) every
// clause's satisfied / implication / conflict flags and its max literal level
// are registered. In REPORT each conflicting clause is offered, lowest index
// first, on a valid/ready channel while a running maximum of the reported
// levels is kept. DONE pulses done_o for one cycle and the block returns to
// IDLE.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             begin an evaluation round (honoured only in IDLE)
//   csat_i              per-clause satisfied flag
//   freelitcnt_i        per-clause 2-bit free-literal count
//   clause_len_i        per-clause length
//   all_lit_false_i     per-clause all-literals-false flag
//   conflict_c_i        per-clause upstream conflict
//   cmax_lvl_i          per-clause max literal level
//   csat_drv_o          registered satisfied flags
//   imp_drv_o           registered implication flags (free count == 1)
//   conflict_c_drv_o    registered conflict flags
//   all_sat_o           registered AND of csat_drv_o
//   conf_valid_o        conflict report valid
//   conf_ready_i        consumer accepts the report
//   conf_cid_o          index of the reported clause
//   conf_lvl_o          level of the reported clause
//   conf_max_lvl_o      running max of accepted report levels this round
//   busy_o              high outside IDLE
//   done_o              one-cycle end-of-round pulse
module terminal_array #(
  parameter int NUM_C       = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CID   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [NUM_C-1:0]             csat_i,
  input  logic [2*NUM_C-1:0]           freelitcnt_i,
  input  logic [NUM_C*WIDTH_C_LEN-1:0] clause_len_i,
  input  logic [NUM_C-1:0]             all_lit_false_i,
  input  logic [NUM_C-1:0]             conflict_c_i,
  input  logic [NUM_C*WIDTH_LVL-1:0]   cmax_lvl_i,
  output logic [NUM_C-1:0]             csat_drv_o,
  output logic [NUM_C-1:0]             imp_drv_o,
  output logic [NUM_C-1:0]             conflict_c_drv_o,
  output logic                         all_sat_o,
  output logic                         conf_valid_o,
  input  logic                         conf_ready_i,
  output logic [WIDTH_CID-1:0]         conf_cid_o,
  output logic [WIDTH_LVL-1:0]         conf_lvl_o,
  output logic [WIDTH_LVL-1:0]         conf_max_lvl_o,
  output logic                         busy_o,
  output logic                         done_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPORT  = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [NUM_C-1:0]                csat_q, imp_q, conf_q;
  logic [NUM_C-1:0]                pending_q, pending_d;
  logic [NUM_C-1:0][WIDTH_LVL-1:0] lvl_q;
  logic                            all_sat_q;
  logic                            valid_q, valid_d;
  logic [WIDTH_CID-1:0]            cid_q, cid_d;
  logic [WIDTH_LVL-1:0]            clvl_q, clvl_d;
  logic [WIDTH_LVL-1:0]            max_q, max_d;

  logic [NUM_C-1:0]                imp_in, conf_in;
  logic [NUM_C-1:0][WIDTH_LVL-1:0] lvl_in;
  logic                            hs;
  logic [NUM_C-1:0]                pend_after_hs;

  // Lowest set index of a clause vector; '0 when empty.
  function automatic logic [WIDTH_CID-1:0] lowest(input logic [NUM_C-1:0] v);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_C; i++) begin
      if (v[i] && !found) begin
        lowest = WIDTH_CID'(i);
        found  = 1'b1;
      end
    end
  endfunction

  // Per-clause evaluation of the live inputs.
  always_comb begin
    imp_in  = '0;
    conf_in = '0;
    lvl_in  = '0;
    for (int unsigned k = 0; k < NUM_C; k++) begin
      imp_in[k]  = (freelitcnt_i[2*k +: 2] == 2'b01);
      conf_in[k] = conflict_c_i[k] |
                   (all_lit_false_i[k] &
                    (clause_len_i[k*WIDTH_C_LEN +: WIDTH_C_LEN] != '0));
      lvl_in[k]  = cmax_lvl_i[k*WIDTH_LVL +: WIDTH_LVL];
    end
  end

  // valid_q is only ever set while in REPORT, so it fully qualifies the handshake.
  assign hs            = valid_q & conf_ready_i;
  assign pend_after_hs = pending_q & ~(NUM_C'(1) << cid_q);

  // Report channel next state. The next clause is preloaded into cid/lvl so it
  // appears the cycle after a handshake; when nothing remains cid/lvl hold.
  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    cid_d     = cid_q;
    clvl_d    = clvl_q;
    max_d     = max_q;
    unique case (state_q)
      CAPTURE: begin
        pending_d = conf_in;
        valid_d   = |conf_in;
        max_d     = '0;
        if (|conf_in) begin
          cid_d  = lowest(conf_in);
          clvl_d = lvl_in[lowest(conf_in)];
        end
      end
      REPORT: begin
        if (hs) begin
          pending_d = pend_after_hs;
          valid_d   = |pend_after_hs;
          if (clvl_q > max_q) max_d = clvl_q;
          if (|pend_after_hs) begin
            cid_d  = lowest(pend_after_hs);
            clvl_d = lvl_q[lowest(pend_after_hs)];
          end
        end
      end
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = CAPTURE;
      CAPTURE: state_d = REPORT;
      REPORT:  if (pending_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csat_q    <= '0;
      imp_q     <= '0;
      conf_q    <= '0;
      lvl_q     <= '0;
      all_sat_q <= 1'b0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      cid_q     <= '0;
      clvl_q    <= '0;
      max_q     <= '0;
    end else begin
      if (state_q == CAPTURE) begin
        csat_q    <= csat_i;
        imp_q     <= imp_in;
        conf_q    <= conf_in;
        lvl_q     <= lvl_in;
        all_sat_q <= &csat_i;
      end
      pending_q <= pending_d;
      valid_q   <= valid_d;
      cid_q     <= cid_d;
      clvl_q    <= clvl_d;
      max_q     <= max_d;
    end
  end

  assign csat_drv_o       = csat_q;
  assign imp_drv_o        = imp_q;
  assign conflict_c_drv_o = conf_q;
  assign all_sat_o        = all_sat_q;
  assign conf_valid_o     = valid_q;
  assign conf_cid_o       = cid_q;
  assign conf_lvl_o       = clvl_q;
  assign conf_max_lvl_o   = max_q;

endmodule

// File: tb/tb_terminal_array.sv
// Bench for terminal_array: directed rounds plus randomized rounds checked
// against a per-round reference model (expected flags and an ordered queue of
// conflict reports).
module tb_terminal_array;
  localparam int NUM_C = 8;
  localparam int WL    = 16;
  localparam int WCL   = 4;
  localparam int WCID  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i;
  logic [NUM_C-1:0]    csat_i;
  logic [2*NUM_C-1:0]  freelitcnt_i;
  logic [NUM_C*WCL-1:0] clause_len_i;
  logic [NUM_C-1:0]    all_lit_false_i;
  logic [NUM_C-1:0]    conflict_c_i;
  logic [NUM_C*WL-1:0] cmax_lvl_i;
  logic [NUM_C-1:0]    csat_drv_o, imp_drv_o, conflict_c_drv_o;
  logic                all_sat_o, conf_valid_o, conf_ready_i, busy_o, done_o;
  logic [WCID-1:0]     conf_cid_o;
  logic [WL-1:0]       conf_lvl_o, conf_max_lvl_o;

  terminal_array #(
    .NUM_C      (NUM_C),
    .WIDTH_LVL  (WL),
    .WIDTH_C_LEN(WCL),
    .WIDTH_CID  (WCID)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .csat_i          (csat_i),
    .freelitcnt_i    (freelitcnt_i),
    .clause_len_i    (clause_len_i),
    .all_lit_false_i (all_lit_false_i),
    .conflict_c_i    (conflict_c_i),
    .cmax_lvl_i      (cmax_lvl_i),
    .csat_drv_o      (csat_drv_o),
    .imp_drv_o       (imp_drv_o),
    .conflict_c_drv_o(conflict_c_drv_o),
    .all_sat_o       (all_sat_o),
    .conf_valid_o    (conf_valid_o),
    .conf_ready_i    (conf_ready_i),
    .conf_cid_o      (conf_cid_o),
    .conf_lvl_o      (conf_lvl_o),
    .conf_max_lvl_o  (conf_max_lvl_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Last reported clause; cid/lvl outputs must keep it while valid is low.
  int          exp_last_cid = 0;
  logic [WL-1:0] exp_last_lvl = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    start_i         = 1'b0;
    csat_i          = '0;
    freelitcnt_i    = '0;
    clause_len_i    = '0;
    all_lit_false_i = '0;
    conflict_c_i    = '0;
    cmax_lvl_i      = '0;
    conf_ready_i    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_csat"},    csat_drv_o, 0);
    chk({tag, "_imp"},     imp_drv_o, 0);
    chk({tag, "_conf"},    conflict_c_drv_o, 0);
    chk({tag, "_allsat"},  all_sat_o, 0);
    chk({tag, "_valid"},   conf_valid_o, 0);
    chk({tag, "_cid"},     conf_cid_o, 0);
    chk({tag, "_lvl"},     conf_lvl_o, 0);
    chk({tag, "_maxlvl"},  conf_max_lvl_o, 0);
    chk({tag, "_busy"},    busy_o, 0);
    chk({tag, "_done"},    done_o, 0);
  endtask

  task automatic set_clause(input int k, input bit alf, input int len, input int lvl);
    all_lit_false_i[k]        = alf;
    clause_len_i[k*WCL +: WCL] = WCL'(len);
    cmax_lvl_i[k*WL +: WL]    = WL'(lvl);
  endtask

  // Runs a full round from IDLE using the current inputs.
  // ready_mode: 0 = ready tied high, 1 = random ready, 2 = ready low for 5
  // valid cycles before each acceptance.
  task automatic run_round(input int ready_mode, output logic [WL-1:0] final_max);
    int            q[$];
    logic [WL-1:0] lv[NUM_C];
    logic [NUM_C-1:0] e_csat, e_imp, e_conf;
    logic [WL-1:0] e_max;
    int            post, held;
    bit            r, finished;

    e_csat = '0; e_imp = '0; e_conf = '0;
    for (int k = 0; k < NUM_C; k++) begin
      lv[k]     = cmax_lvl_i[k*WL +: WL];
      e_csat[k] = csat_i[k];
      e_imp[k]  = (int'(freelitcnt_i[2*k +: 2]) == 1);
      e_conf[k] = conflict_c_i[k] ||
                  (all_lit_false_i[k] && int'(clause_len_i[k*WCL +: WCL]) > 0);
      if (e_conf[k]) q.push_back(k);
    end

    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_capture", busy_o, 1);
    chk("valid_capture", conf_valid_o, 0);
    @(posedge clk); #1;
    chk("csat_drv", csat_drv_o, e_csat);
    chk("imp_drv", imp_drv_o, e_imp);
    chk("conflict_drv", conflict_c_drv_o, e_conf);
    chk("all_sat", all_sat_o, (e_csat == '1));

    e_max = '0; post = 0; held = 0; finished = 0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (q.size() > 0) begin
        chk("valid", conf_valid_o, 1);
        chk("cid", conf_cid_o, q[0]);
        chk("lvl", conf_lvl_o, lv[q[0]]);
        chk("busy_report", busy_o, 1);
        exp_last_cid = q[0];
        exp_last_lvl = lv[q[0]];
      end else begin
        chk("valid_low", conf_valid_o, 0);
        chk("cid_hold", conf_cid_o, exp_last_cid);
        chk("lvl_hold", conf_lvl_o, exp_last_lvl);
        chk("done", done_o, (post == 1));
        chk("busy_tail", busy_o, 1);
      end
      chk("max_lvl", conf_max_lvl_o, e_max);
      if (q.size() == 0 && post == 1) begin
        finished = 1;
      end else begin
        case (ready_mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom_range(0, 1));
          default: r = (held >= 5);
        endcase
        conf_ready_i = r;
        if (q.size() > 0) begin
          if (r) begin
            if (lv[q[0]] > e_max) e_max = lv[q[0]];
            void'(q.pop_front());
            held = 0;
          end else begin
            held++;
          end
        end else begin
          post++;
        end
        @(posedge clk); #1;
      end
    end
    if (!finished) chk("round_timeout", 0, 1);

    conf_ready_i = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", done_o, 0);
    chk("busy_idle", busy_o, 0);
    chk("max_after", conf_max_lvl_o, e_max);
    final_max = e_max;
  endtask

  initial begin
    logic [WL-1:0] fmax;

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy_o, 0);

    // All satisfied, no conflicts
    clear_inputs();
    csat_i = '1;
    freelitcnt_i = 16'h5555;
    run_round(0, fmax);

    // Clauses 2 and 5 conflicting via all-literals-false
    clear_inputs();
    set_clause(2, 1'b1, 3, 7);
    set_clause(5, 1'b1, 3, 4);
    run_round(0, fmax);
    chk("dir2_max", fmax, 7);

    // Zero-length clause does not conflict; upstream conflict does
    clear_inputs();
    set_clause(1, 1'b1, 0, 9);
    conflict_c_i[3] = 1'b1;
    cmax_lvl_i[3*WL +: WL] = 16'd12;
    run_round(0, fmax);
    chk("dir3_max", fmax, 12);

    // Single conflict held off by ready for five cycles
    clear_inputs();
    set_clause(6, 1'b1, 2, 16'h8001);
    run_round(2, fmax);

    // Free-literal counts 01, 11, 00, 10 on clauses 0..3
    clear_inputs();
    freelitcnt_i[7:0] = 8'b10_00_11_01;
    run_round(0, fmax);
    chk("dir5_imp", imp_drv_o[3:0], 4'b0001);

    // Reset in REPORT with three pending reports
    clear_inputs();
    csat_i = 8'hA5;
    set_clause(1, 1'b1, 5, 100);
    set_clause(4, 1'b1, 1, 200);
    conflict_c_i[6] = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", conf_valid_o, 1);
    chk("pre_rst_cid", conf_cid_o, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    rst = 1'b0;
    exp_last_cid = 0;
    exp_last_lvl = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", conf_valid_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end

    // Randomized rounds
    for (int t = 0; t < 30; t++) begin
      clear_inputs();
      csat_i          = NUM_C'($urandom);
      if ($urandom_range(0, 3) == 0) csat_i = '1;
      freelitcnt_i    = 16'($urandom);
      clause_len_i    = 32'($urandom);
      for (int k = 0; k < NUM_C; k++)
        if ($urandom_range(0, 3) == 0) clause_len_i[k*WCL +: WCL] = '0;
      all_lit_false_i = NUM_C'($urandom) & NUM_C'($urandom);
      conflict_c_i    = NUM_C'($urandom) & NUM_C'($urandom) & NUM_C'($urandom);
      for (int k = 0; k < NUM_C; k++) cmax_lvl_i[k*WL +: WL] = WL'($urandom);
      run_round(($urandom_range(0, 3) == 0) ? 2 : 1, fmax);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/terminal_array.md
TERMINAL_ARRAY -- requirements
Module: terminal_array

Interface
REQ-001 SHALL have parameter NUM_C, default 8: number of clause terminals handled.
REQ-002 SHALL have parameter WIDTH_LVL, default 16: decision-level width.
REQ-003 SHALL have parameter WIDTH_C_LEN, default 4: clause-length width.
REQ-004 SHALL have parameter WIDTH_CID, default 3: clause-index width, with 2**WIDTH_CID >= NUM_C.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  begins an evaluation round.
- csat_i  in  NUM_C  per-clause satisfied flag.
- freelitcnt_i  in  2*NUM_C  per-clause free-literal count; clause k at bits [2k+1:2k].
- clause_len_i  in  NUM_C*WIDTH_C_LEN  per-clause length; clause k in slice k.
- all_lit_false_i  in  NUM_C  per-clause all-literals-false flag.
- conflict_c_i  in  NUM_C  per-clause upstream conflict.
- cmax_lvl_i  in  NUM_C*WIDTH_LVL  per-clause max literal level; clause k in slice k.
- csat_drv_o  out  NUM_C  registered satisfied flags.
- imp_drv_o  out  NUM_C  registered implication flags.
- conflict_c_drv_o  out  NUM_C  registered conflict flags.
- all_sat_o  out  1  registered AND of csat_drv_o.
- conf_valid_o  out  1  conflict report valid.
- conf_ready_i  in  1  consumer accepts the report.
- conf_cid_o  out  WIDTH_CID  index of the reported clause.
- conf_lvl_o  out  WIDTH_LVL  cmax_lvl of the reported clause.
- conf_max_lvl_o  out  WIDTH_LVL  running maximum level over the clauses reported so far this round.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse at the end of a round.

Function
REQ-006 SHALL implement FSM states IDLE, CAPTURE, REPORT and DONE.
REQ-007 SHALL, in IDLE with start_i=1, go to CAPTURE next cycle; start_i outside IDLE SHALL be ignored.
REQ-008 SHALL, in CAPTURE, register for every clause k:
- csat_drv_o[k] = csat_i[k]
- imp_drv_o[k] = (freelitcnt_i[k] == 2'b01); values 00, 10 and 11 give 0.
- conflict_c_drv_o[k] = conflict_c_i[k] | (all_lit_false_i[k] & clause_len_i[k] != 0)
- lvl[k] = cmax_lvl_i[k]
- pending[k] = conflict_c_drv_o[k]
REQ-009 SHALL capture inputs only in CAPTURE; registered per-clause outputs and all_sat_o SHALL hold until the next CAPTURE or reset.
REQ-010 SHALL, in CAPTURE, clear conf_max_lvl_o to 0, then go to REPORT.
REQ-011 SHALL, in REPORT with pending != 0, drive conf_valid_o=1, conf_cid_o = lowest set pending index, conf_lvl_o = lvl of that index.
REQ-012 SHALL hold conf_valid_o, conf_cid_o and conf_lvl_o stable until the cycle where conf_valid_o & conf_ready_i.
REQ-013 SHALL, on that handshake cycle:
- clear the pending bit.
- update conf_max_lvl_o = max(conf_max_lvl_o, conf_lvl_o), using an unsigned compare.
- present the next pending clause in the following cycle; no bubble is required.
REQ-014 SHALL, in REPORT with pending == 0, drive conf_valid_o=0 and go to DONE; a round with no conflicts therefore spends one cycle in REPORT.
REQ-015 SHALL, in DONE, assert done_o for exactly one cycle and return to IDLE.
REQ-016 SHALL ignore conf_ready_i whenever conf_valid_o=0.
REQ-017 SHALL keep conf_cid_o, conf_lvl_o and conf_max_lvl_o unchanged while conf_valid_o=0.
REQ-018 SHALL treat clause indices >= NUM_C as non-existent; they are never reported.
REQ-019 SHALL give latency start_i -> first conf_valid_o of 2 cycles (IDLE->CAPTURE->REPORT).

Reset
REQ-020 SHALL, on rst=1 at any time including mid-round:
- enter IDLE immediately.
- clear pending, all per-clause output registers, all_sat_o, conf_valid_o, conf_cid_o, conf_lvl_o, conf_max_lvl_o, busy_o and done_o to 0.
REQ-021 SHALL, after rst deasserts, not start a round until a new start_i is seen in IDLE.

Verification
REQ-022 SHALL be verified with NUM_C=8 and these directed scenarios:
- All csat_i=1, no conflicts, start_i -> all_sat_o=1; conf_valid_o never high; done_o pulses on cycle 3 after start.
- Clauses 2 and 5 with all_lit_false=1, len 3, lvl 7 and 4; conf_ready_i tied high -> reports cid 2/lvl 7, then cid 5/lvl 4; conf_max_lvl_o ends at 7; done_o pulses.
- Clause 1 with all_lit_false=1 and len 0; clause 3 with conflict_c_i=1 -> only cid 3 is reported.
- conf_ready_i low for 5 cycles with one conflict -> conf_valid_o, cid and lvl stable for 5 cycles; accepted on the 6th.
- freelitcnt = 01, 11, 00, 10 on clauses 0..3 -> imp_drv_o[3:0] = 0001.
- rst pulsed while in REPORT with 3 pending -> all outputs 0 next cycle; no report until a new start_i.
